// File: rtl/sram1rw2048x8_ctrl.sv
// Request-side controller for the SRAM1RW2048x8 single-port macro.
// Turns a valid/ready read/write stream into the macro's active-low pins,
// buffers registered read data in a 2-entry response FIFO, and can
// zero-fill the array after reset.
module sram1rw2048x8_ctrl #(
  parameter int unsigned        ADDR_W     = 11,
  parameter int unsigned        DATA_W     = 8,
  parameter int unsigned        DEPTH      = 2048,
  parameter bit                 INIT_CLEAR = 1'b1,
  parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              mem_CE,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_I,
  output logic              mem_CSB,
  output logic              mem_WEB,
  output logic              mem_OEB,
  input  logic [DATA_W-1:0] mem_O
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                init_done_q, init_done_d;
  logic                rd_pending_q, rd_pending_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   i_q, i_d;
  logic [DATA_W-1:0]   fifo_q [2];

  logic                fire, wr_fire, rd_fire, push, pop;
  logic [2:0]          occ;

  // Handshake: an entry popped this cycle frees its slot for a new read.
  always_comb begin
    pop        = (cnt_q != 2'd0) && resp_ready;
    push       = rd_pending_q;
    occ        = 3'(cnt_q) + 3'(rd_pending_q) - 3'(pop);
    req_ready  = reset_n && (state_q == ST_RUN) && (req_write || (occ < 3'd2));
    fire       = req_valid && req_ready;
    wr_fire    = fire && req_write;
    rd_fire    = fire && !req_write;
    resp_valid = (cnt_q != 2'd0);
    resp_rdata = fifo_q[rd_ptr_q];
    init_done  = init_done_q;
    mem_CE     = clock;
  end

  // Macro pin drive; address and data hold their last driven value when idle.
  always_comb begin
    mem_CSB = 1'b1;
    mem_WEB = 1'b1;
    mem_OEB = 1'b1;
    mem_A   = a_q;
    mem_I   = i_q;
    if (reset_n) begin
      if (state_q == ST_INIT) begin
        mem_CSB = 1'b0;
        mem_WEB = 1'b0;
        mem_A   = clr_cnt_q;
        mem_I   = INIT_VALUE;
      end else if (wr_fire) begin
        mem_CSB = 1'b0;
        mem_WEB = 1'b0;
        mem_A   = req_addr;
        mem_I   = req_wdata;
      end else if (rd_fire) begin
        mem_CSB = 1'b0;
        mem_OEB = 1'b0;
        mem_A   = req_addr;
      end
    end
    a_d = mem_A;
    i_d = mem_I;
  end

  // Next-state: clear sweep sequencing, read pipeline and FIFO bookkeeping.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    init_done_d  = init_done_q;
    rd_pending_d = rd_fire;
    wr_ptr_d     = wr_ptr_q ^ push;
    rd_ptr_d     = rd_ptr_q ^ pop;
    cnt_d        = cnt_q + 2'(push) - 2'(pop);
    if (state_q == ST_INIT) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == LAST_ADDR) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= INIT_CLEAR ? ST_INIT : ST_RUN;
      clr_cnt_q    <= '0;
      init_done_q  <= !INIT_CLEAR;
      rd_pending_q <= 1'b0;
      cnt_q        <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      a_q          <= '0;
      i_q          <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      init_done_q  <= init_done_d;
      rd_pending_q <= rd_pending_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      a_q          <= a_d;
      i_q          <= i_d;
    end
  end

  // Response storage; capture macro output one edge after the read.
  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      fifo_q[wr_ptr_q] <= mem_O;
    end
  end

`ifndef SYNTHESIS
  // The read credit check must make a push into a full FIFO impossible.
  always_ff @(posedge clock) begin
    if (reset_n && push && !pop) begin
      assert (cnt_q != 2'd2) else $error("response FIFO overflow");
    end
  end
`endif

endmodule

// File: tb/tb_sram1rw2048x8_ctrl.sv
// Directed bench for sram1rw2048x8_ctrl with a behavioural macro model.
module tb_sram1rw2048x8_ctrl;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2048;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // DUT 0: INIT_CLEAR = 1
  logic          rst_n, req_valid, req_ready, req_write, resp_valid, resp_ready, init_done;
  logic [AW-1:0] req_addr, mem_a;
  logic [DW-1:0] req_wdata, resp_rdata, mem_i, mem_o;
  logic          mem_ce, mem_csb, mem_web, mem_oeb;

  // DUT 1: INIT_CLEAR = 0
  logic          rst1_n, req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, init_done1;
  logic [AW-1:0] req_addr1, mem_a1;
  logic [DW-1:0] req_wdata1, resp_rdata1, mem_i1, mem_o1;
  logic          mem_ce1, mem_csb1, mem_web1, mem_oeb1;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

  int n_chk  = 0;
  int n_fail = 0;
  int bad;
  logic [23:0]   exp_sw;
  logic [DW-1:0] exp_s [16];

  sram1rw2048x8_ctrl #(.INIT_CLEAR(1'b1)) u_dut0 (
    .clock(clock), .reset_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done), .mem_CE(mem_ce), .mem_A(mem_a), .mem_I(mem_i),
    .mem_CSB(mem_csb), .mem_WEB(mem_web), .mem_OEB(mem_oeb), .mem_O(mem_o)
  );

  sram1rw2048x8_ctrl #(.INIT_CLEAR(1'b0)) u_dut1 (
    .clock(clock), .reset_n(rst1_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1),
    .init_done(init_done1), .mem_CE(mem_ce1), .mem_A(mem_a1), .mem_I(mem_i1),
    .mem_CSB(mem_csb1), .mem_WEB(mem_web1), .mem_OEB(mem_oeb1), .mem_O(mem_o1)
  );

  // Macro models: random power-up contents, pins sampled on the CE rising edge.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem0[i] = DW'($urandom);
    forever begin
      @(posedge mem_ce);
      if (!mem_csb) begin
        if (!mem_web) mem0[mem_a] = mem_i;
        else if (!mem_oeb) mem_o <= mem0[mem_a];
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem1[i] = DW'($urandom);
    forever begin
      @(posedge mem_ce1);
      if (!mem_csb1) begin
        if (!mem_web1) mem1[mem_a1] = mem_i1;
        else if (!mem_oeb1) mem_o1 <= mem1[mem_a1];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    rst1_n = 1'b0; req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; resp_ready1 = 1'b1;
    cyc(); cyc();

    // Reset values
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_pins", 32'({mem_csb, mem_web, mem_oeb}), 32'b111);
    chk("nc_init_done", 32'(init_done1), 32'd1);

    // INIT_CLEAR=0: read of an unwritten address returns power-up content
    rst1_n = 1'b1; req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 11'h123;
    #1;
    chk("nc_ready", 32'(req_ready1), 32'd1);
    chk("nc_rd_pins", 32'({mem_csb1, mem_web1, mem_oeb1, mem_a1}), 32'({3'b010, 11'h123}));
    cyc(); req_valid1 = 1'b0; #1;
    chk("nc_valid_t1", 32'(resp_valid1), 32'd0);
    cyc();
    chk("nc_valid_t2", 32'(resp_valid1), 32'd1);
    chk("nc_rdata", 32'(resp_rdata1), 32'(mem1[11'h123]));
    chk("nc_ready_idle", 32'(req_ready1), 32'd1);
    cyc();
    chk("nc_valid_pop", 32'(resp_valid1), 32'd0);

    // Clear sweep: DEPTH write cycles with A = 0..DEPTH-1, I = 0
    rst_n = 1'b1; #1;
    for (int k = 0; k < int'(DEPTH); k++) begin
      exp_sw = {3'b001, AW'(k), 8'h00, 2'b00};
      chk("sweep", 32'({mem_csb, mem_web, mem_oeb, mem_a, mem_i, req_ready, init_done}), 32'(exp_sw));
      cyc();
    end
    chk("sweep_done", 32'(init_done), 32'd1);
    chk("sweep_idle_pins", 32'({mem_csb, mem_web, mem_oeb}), 32'b111);
    chk("sweep_ready", 32'(req_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mem0[i] !== 8'h00) bad++;
    chk("sweep_backdoor", 32'(bad), 32'd0);

    // Write 8'hA5 to 11'h7FF then read it back on the next cycle
    req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h7FF; req_wdata = 8'hA5; #1;
    chk("wr_pins", 32'({mem_csb, mem_web, mem_oeb, mem_a, mem_i}), 32'({3'b001, 11'h7FF, 8'hA5}));
    cyc(); req_write = 1'b0; #1;
    chk("rd_pins", 32'({mem_csb, mem_web, mem_oeb, mem_a}), 32'({3'b010, 11'h7FF}));
    cyc(); req_valid = 1'b0; #1;
    chk("wr_rd_valid_t1", 32'(resp_valid), 32'd0);
    chk("idle_hold_a", 32'({mem_csb, mem_web, mem_oeb, mem_a}), 32'({3'b111, 11'h7FF}));
    cyc();
    chk("wr_rd_valid_t2", 32'(resp_valid), 32'd1);
    chk("wr_rd_data", 32'(resp_rdata), 32'h0A5);
    cyc();
    chk("wr_rd_popped", 32'(resp_valid), 32'd0);

    // Backpressure: fill addrs 1..4, then read them with resp_ready low
    req_valid = 1'b1; req_write = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      req_addr = AW'(i); req_wdata = DW'(8'h11 * i); cyc();
    end
    resp_ready = 1'b0; req_write = 1'b0; req_addr = 11'd1; #1;
    chk("bp_rd1_ready", 32'(req_ready), 32'd1);
    cyc(); req_addr = 11'd2; #1;
    chk("bp_rd2_ready", 32'(req_ready), 32'd1);
    cyc(); req_addr = 11'd3; #1;
    chk("bp_rd3_blocked", 32'(req_ready), 32'd0);
    chk("bp_no_fire_pins", 32'({mem_csb, mem_web, mem_oeb}), 32'b111);
    cyc();
    chk("bp_full_blocked", 32'(req_ready), 32'd0);
    chk("bp_head1", 32'({resp_valid, resp_rdata}), 32'({1'b1, 8'h11}));
    resp_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    cyc(); req_addr = 11'd4; #1;
    chk("bp_head2", 32'({resp_valid, resp_rdata}), 32'({1'b1, 8'h22}));
    chk("bp_rd4_ready", 32'(req_ready), 32'd1);
    cyc(); req_valid = 1'b0; #1;
    chk("bp_head3", 32'({resp_valid, resp_rdata}), 32'({1'b1, 8'h33}));
    cyc();
    chk("bp_head4", 32'({resp_valid, resp_rdata}), 32'({1'b1, 8'h44}));
    cyc();
    chk("bp_drained", 32'(resp_valid), 32'd0);

    // Streaming: 16 back-to-back reads, one response per cycle after fill
    req_valid = 1'b1; req_write = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_s[i] = DW'(16 + i) ^ 8'h5A;
      req_addr = AW'(16 + i); req_wdata = exp_s[i]; cyc();
    end
    req_write = 1'b0;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin req_valid = 1'b1; req_addr = AW'(16 + c); end
      else req_valid = 1'b0;
      #1;
      if (c < 16) chk("st_ready", 32'(req_ready), 32'd1);
      if (c >= 2) chk("st_resp", 32'({resp_valid, resp_rdata}), 32'({1'b1, exp_s[c-2]}));
      else chk("st_fill", 32'(resp_valid), 32'd0);
      cyc();
    end
    chk("st_drained", 32'(resp_valid), 32'd0);

    // Reset with two reads in flight: no responses, sweep restarts at 0
    req_valid = 1'b1; req_addr = 11'd1; cyc();
    req_addr = 11'd2; cyc();
    req_valid = 1'b0; rst_n = 1'b0; #1;
    chk("mr_idle_pins", 32'({mem_csb, mem_web, mem_oeb}), 32'b111);
    chk("mr_ready", 32'(req_ready), 32'd0);
    cyc(); rst_n = 1'b1; #1;
    chk("mr_valid", 32'(resp_valid), 32'd0);
    chk("mr_init_done", 32'(init_done), 32'd0);
    chk("mr_sweep0", 32'({mem_csb, mem_web, mem_oeb, mem_a}), 32'({3'b001, 11'd0}));
    cyc();
    chk("mr_valid2", 32'(resp_valid), 32'd0);
    chk("mr_sweep1", 32'(mem_a), 32'd1);
    cyc();
    chk("mr_valid3", 32'(resp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram1rw2048x8_ctrl.md
Name: sram1rw2048x8_ctrl

Overview:
Request-side controller directly upstream of the SRAM1RW2048x8 single-port macro. Converts a valid/ready read/write request stream into the macro's active-low pin protocol (CSB/WEB/OEB, A, I). Captures the macro's registered read data O into a 2-entry response FIFO with valid/ready backpressure. Optionally zero-fills the whole array after reset, because the macro powers up with random contents.

Parameters:
ADDR_W, 11, address width; DEPTH must equal 2**ADDR_W
DATA_W, 8, data width
DEPTH, 2048, number of words
INIT_CLEAR, 1, 1 = sweep-write INIT_VALUE to every word after reset
INIT_VALUE, 8'h00, fill value used by the sweep

Ports:
clock  input  1  single clock; also drives macro CE
reset_n  input  1  synchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when valid&ready (fire)
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
resp_valid  output  1  read data available
resp_ready  input  1  consumer accepts read data
resp_rdata  output  DATA_W  read data, head of FIFO
init_done  output  1  high once the clear sweep is finished (or immediately if INIT_CLEAR=0)
mem_CE  output  1  = clock, pass-through
mem_A  output  ADDR_W  macro address
mem_I  output  DATA_W  macro write data
mem_CSB  output  1  macro chip select, active-low
mem_WEB  output  1  macro write enable, active-low
mem_OEB  output  1  macro read enable, active-low
mem_O  input  DATA_W  macro read data; updates on the CE edge that samples a read

Behaviour:
- Macro model: pins sampled at rising clock edge. Read at edge t puts data on mem_O after t; mem_O holds its value until the next read.
- States: INIT, RUN. Reset (reset_n=0 at an edge) enters INIT if INIT_CLEAR=1, else RUN. Reset also clears clr_cnt, the FIFO, and rd_pending.
- While reset_n=0, pins are idle (CSB=WEB=OEB=1) combinationally.
- INIT:
  - req_ready=0, init_done=0.
  - Each cycle drives CSB=0, WEB=0, OEB=1, A=clr_cnt, I=INIT_VALUE.
  - clr_cnt increments by 1 per cycle. The cycle with clr_cnt=DEPTH-1 is the last write; the next state is RUN.
  - Total duration is exactly DEPTH cycles. init_done goes 1 in the first RUN cycle.
- RUN, pin drive (combinational from the request when it fires):
  - Write fire: CSB=0, WEB=0, OEB=1, A=req_addr, I=req_wdata.
  - Read fire: CSB=0, WEB=1, OEB=0, A=req_addr.
  - No fire: CSB=WEB=OEB=1. A and I hold their last driven values.
- RUN, ready rules:
  - Writes: req_ready=1.
  - Reads: req_ready = (fifo_count + rd_pending) < 2 (credit check). req_ready is the combination of both rules, evaluated against req_write.
- Read pipeline and latency:
  - Read fires at edge t: rd_pending<=1.
  - At edge t+1, mem_O is pushed into the FIFO and rd_pending clears unless a new read fires at t+1.
  - resp_valid=1 from cycle t+2. Read latency is 2 cycles; back-to-back reads sustain 1 per cycle while resp_ready=1.
- FIFO:
  - 2 entries, in-order. Pop on resp_valid&resp_ready.
  - Simultaneous push and pop is legal; count is unchanged.
  - Credit rule guarantees no push when full; overflow is impossible. A push into a full FIFO is a design error; a simulation assertion is required.
  - resp_valid=0 when empty. resp_rdata is undefined when resp_valid=0.
- Ordering:
  - A write at edge t followed by a read of the same address at edge t+1 returns the new data.
  - Writes never generate responses.
- Reset mid-operation: pending reads and buffered data are discarded and no response is emitted. A sweep interrupted by reset restarts from address 0.
- Reset values: req_ready=0, resp_valid=0, init_done=0 (1 after the first edge if INIT_CLEAR=0), CSB=WEB=OEB=1, clr_cnt=0.

Test Plan:
- Init sweep: INIT_CLEAR=1, release reset → CSB=0/WEB=0 for exactly 2048 cycles with A=0..2047 and I=0. init_done rises in cycle 2049. Backdoor check: all words = 8'h00.
- Write/read: write 8'hA5 to addr 11'h7FF, next cycle read 11'h7FF → resp_valid 2 cycles after read fire, resp_rdata=8'hA5.
- Backpressure: resp_ready=0, issue 4 reads to addrs 1..4 → only 2 accepted (req_ready drops with 2 credits outstanding). Raise resp_ready → data for addrs 1,2 in order, then remaining reads accepted.
- Streaming: resp_ready=1, 16 back-to-back reads → 1 response per cycle, in order, no bubbles after the 2-cycle fill.
- Reset mid-stream: 2 reads in flight, assert reset_n=0 for one edge → resp_valid=0 next cycle, no stale responses, sweep restarts at A=0.
- INIT_CLEAR=0: init_done=1 in the first cycle after reset. A read of an unwritten address returns the macro's random content without X-propagation on the handshake signals.
